// File: rtl/cnv_pkg.sv
// Shared definitions for the convolution row sequencer: default geometry, FSM state
// encoding and count-width helpers.
package cnv_pkg;

  localparam int unsigned LENROW    = 16;
  localparam int unsigned NBLK_W    = 6;
  localparam int unsigned NUM_LANES = 3;

  // A width of zero would be illegal for a one-position row.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned POS_W = cnt_w(LENROW);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSta,
    StWait,
    StAcc,
    StDone
  } state_e;

endpackage

// File: rtl/cnv_row_seq_fnh_join.sv
// Joins the three MAC-lane finish pulses: sticky per-lane latches plus a combined
// all-done flag that also counts a pulse arriving in the current cycle.
module fnh_join
  import cnv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [NUM_LANES-1:0] i_fnh,
  output logic                 o_all_done
);

  logic [NUM_LANES-1:0] r_latch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_latch <= '0;
    end else if (i_clr) begin
      r_latch <= '0;
    end else if (i_en) begin
      r_latch <= r_latch | i_fnh;
    end
  end

  // Pulses outside the enable window never contribute.
  assign o_all_done = i_en & (&(r_latch | i_fnh));

endmodule

// File: rtl/cnv_row_seq.sv
// Row sequencer for the convolution PE: per output position, runs NumBlk MAC passes
// (load, start, wait for all three lanes), then shifts the psum row; ends with FnhRow.
module cnv_row_seq #(
  parameter int unsigned LENROW = cnv_pkg::LENROW,
  parameter int unsigned NBLK_W = cnv_pkg::NBLK_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 Row_Sta,
  output logic                                 Row_Rdy,
  input  logic [NBLK_W-1:0]                    Cfg_NumBlk,
  input  logic                                 Blk_Vld,
  output logic                                 Blk_Rdy,
  output logic                                 PECMAC_Sta,
  input  logic                                 MACPEC_Fnh0,
  input  logic                                 MACPEC_Fnh1,
  input  logic                                 MACPEC_Fnh2,
  output logic                                 PECCNV_PlsAcc,
  output logic                                 PECCNV_FnhRow,
  output logic [cnv_pkg::cnt_w(LENROW)-1:0]    Cnt_Pos,
  output logic [NBLK_W-1:0]                    Cnt_Blk
);

  import cnv_pkg::state_e;
  import cnv_pkg::StIdle;
  import cnv_pkg::StLoad;
  import cnv_pkg::StSta;
  import cnv_pkg::StWait;
  import cnv_pkg::StAcc;
  import cnv_pkg::StDone;

  localparam int unsigned     PosW    = cnv_pkg::cnt_w(LENROW);
  localparam logic [PosW-1:0] PosLast = PosW'(LENROW - 1);

  state_e            r_state, w_state_nxt;
  logic [PosW-1:0]   r_cnt_pos, w_cnt_pos_nxt;
  logic [NBLK_W-1:0] r_cnt_blk, w_cnt_blk_nxt;
  logic [NBLK_W-1:0] r_num_blk, w_num_blk_nxt;
  logic              w_all_done;
  logic              w_fnh_clr;
  logic              w_fnh_en;
  logic              w_blk_last;
  logic              w_pos_last;

  fnh_join u_fnh_join (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_fnh_clr),
    .i_en       (w_fnh_en),
    .i_fnh      ({MACPEC_Fnh2, MACPEC_Fnh1, MACPEC_Fnh0}),
    .o_all_done (w_all_done)
  );

  assign w_blk_last = (r_cnt_blk == (r_num_blk - NBLK_W'(1)));
  assign w_pos_last = (r_cnt_pos == PosLast);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_pos_nxt = r_cnt_pos;
    w_cnt_blk_nxt = r_cnt_blk;
    w_num_blk_nxt = r_num_blk;

    case (r_state)
      StIdle: begin
        if (Row_Sta) begin
          // A zero block count would never satisfy the last-block compare.
          w_num_blk_nxt = (Cfg_NumBlk == '0) ? NBLK_W'(1) : Cfg_NumBlk;
          w_state_nxt   = StLoad;
        end
      end
      StLoad: begin
        if (Blk_Vld) begin
          w_state_nxt = StSta;
        end
      end
      StSta: begin
        w_state_nxt = StWait;
      end
      StWait: begin
        if (w_all_done) begin
          if (w_blk_last) begin
            w_state_nxt = StAcc;
          end else begin
            w_cnt_blk_nxt = r_cnt_blk + NBLK_W'(1);
            w_state_nxt   = StLoad;
          end
        end
      end
      StAcc: begin
        w_cnt_blk_nxt = '0;
        if (w_pos_last) begin
          w_state_nxt = StDone;
        end else begin
          w_cnt_pos_nxt = r_cnt_pos + PosW'(1);
          w_state_nxt   = StLoad;
        end
      end
      StDone: begin
        w_cnt_pos_nxt = '0;
        w_state_nxt   = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_comb begin
    Row_Rdy       = 1'b0;
    Blk_Rdy       = 1'b0;
    PECMAC_Sta    = 1'b0;
    PECCNV_PlsAcc = 1'b0;
    PECCNV_FnhRow = 1'b0;
    w_fnh_clr     = 1'b0;
    w_fnh_en      = 1'b0;

    case (r_state)
      StIdle: Row_Rdy = 1'b1;
      StLoad: Blk_Rdy = 1'b1;
      StSta: begin
        PECMAC_Sta = 1'b1;
        w_fnh_clr  = 1'b1;
      end
      StWait: w_fnh_en      = 1'b1;
      StAcc:  PECCNV_PlsAcc = 1'b1;
      StDone: PECCNV_FnhRow = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt_pos <= '0;
      r_cnt_blk <= '0;
      r_num_blk <= NBLK_W'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_pos <= w_cnt_pos_nxt;
      r_cnt_blk <= w_cnt_blk_nxt;
      r_num_blk <= w_num_blk_nxt;
    end
  end

  assign Cnt_Pos = r_cnt_pos;
  assign Cnt_Blk = r_cnt_blk;

  a_pulse_excl : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({PECMAC_Sta, PECCNV_PlsAcc, PECCNV_FnhRow}));
  a_blk_bound : assert property (@(posedge clk) disable iff (!rst_n)
    (r_cnt_blk < r_num_blk));

endmodule

// File: doc/cnv_row_seq.md
CNV_ROW_SEQ -- requirements
Module: cnv_row_seq

Interface
REQ-001 SHALL have parameter LENROW, default 16, meaning output positions per row (number of PlsAcc pulses per row).
REQ-002 SHALL have parameter NBLK_W, default 6, meaning width of the channel-block count.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning synchronous active-low reset.
REQ-005 SHALL have port Row_Sta, input, 1 bit, meaning row start request; accepted when Row_Rdy is 1.
REQ-006 SHALL have port Row_Rdy, output, 1 bit, meaning the sequencer is idle and accepts Row_Sta.
REQ-007 SHALL have port Cfg_NumBlk, input, NBLK_W bits, meaning channel blocks per position; sampled on row accept.
REQ-008 SHALL have port Blk_Vld, input, 1 bit, meaning the upstream act/weight block for the next MAC pass is present.
REQ-009 SHALL have port Blk_Rdy, output, 1 bit, meaning the sequencer consumes the block on Blk_Vld & Blk_Rdy.
REQ-010 SHALL have port PECMAC_Sta, output, 1 bit, meaning one-cycle start pulse to all three MAC lanes.
REQ-011 SHALL have ports MACPEC_Fnh0/1/2, input, 1 bit each, meaning one-cycle finish pulses from MAC lanes 0/1/2, in any order.
REQ-012 SHALL have port PECCNV_PlsAcc, output, 1 bit, meaning one-cycle pulse that shifts the psum row.
REQ-013 SHALL have port PECCNV_FnhRow, output, 1 bit, meaning one-cycle end-of-row pulse.
REQ-014 SHALL have port Cnt_Pos, output, clog2(LENROW) bits, meaning the current output position.
REQ-015 SHALL have port Cnt_Blk, output, NBLK_W bits, meaning the current channel block within the position.

Function
REQ-016 SHALL implement the Moore FSM IDLE, LOAD, STA, WAIT, ACC, DONE, with all control outputs decoded from the registered state.
REQ-017 IDLE: Row_Rdy=1; on Row_Sta, SHALL latch NumBlk=Cfg_NumBlk (0 treated as 1) and go to LOAD next cycle.
REQ-018 LOAD: Blk_Rdy=1; on Blk_Vld=1, SHALL go to STA; otherwise SHALL hold indefinitely.
REQ-019 STA: PECMAC_Sta=1 for exactly one cycle; SHALL clear the three finish latches; SHALL go to WAIT.
REQ-020 WAIT: each MACPEC_FnhN SHALL set a sticky latch; "all done" = (latch OR current pulse) for all three lanes.
REQ-021 WAIT, all done, Cnt_Blk==NumBlk-1: SHALL go to ACC.
REQ-022 WAIT, all done, Cnt_Blk<NumBlk-1: SHALL do Cnt_Blk+1 and go to LOAD.
REQ-023 ACC: PECCNV_PlsAcc=1 for one cycle; SHALL set Cnt_Blk=0.
REQ-024 ACC, Cnt_Pos==LENROW-1: SHALL go to DONE; otherwise SHALL do Cnt_Pos+1 and go to LOAD.
REQ-025 DONE: PECCNV_FnhRow=1 for one cycle; SHALL set Cnt_Pos=0 and go to IDLE.
REQ-026 Row_Sta outside IDLE SHALL be ignored.
REQ-027 Fnh pulses outside WAIT (including the STA cycle) SHALL be ignored.
REQ-028 A repeated Fnh on one lane SHALL be idempotent.
REQ-029 Minimum cost: 3 cycles per block and +1 cycle per position (ACC); row end +1 cycle (DONE).
REQ-030 Counters SHALL never wrap: Cnt_Pos ≤ LENROW-1 and Cnt_Blk ≤ NumBlk-1 at all times.
REQ-031 PECMAC_Sta, PECCNV_PlsAcc and PECCNV_FnhRow SHALL be mutually exclusive in every cycle.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, Cnt_Pos=0, Cnt_Blk=0, NumBlk=1 and clear all finish latches.
REQ-033 Outputs after reset SHALL be Row_Rdy=1 and Blk_Rdy=PECMAC_Sta=PECCNV_PlsAcc=PECCNV_FnhRow=0.
REQ-034 Reset mid-row SHALL abandon the row without emitting PECCNV_FnhRow; in-flight Fnh pulses SHALL be discarded.

Structure
REQ-035 Shared package cnv_pkg SHALL hold LENROW, the state enum and the count-width constants.
REQ-036 Sub-module fnh_join (three sticky latches, clear, all-done output) SHALL be instantiated once; the remainder is flat.

Verification
REQ-037 LENROW=4, NumBlk=1, Fnh0/1/2 all 1 cycle after Sta -> 4 PlsAcc pulses, then FnhRow 1 cycle after the last; Row_Rdy=1 on the following cycle.
REQ-038 NumBlk=3, Fnh order 2,0,1 spaced 5 cycles apart -> PlsAcc only after the 3rd block's last Fnh; Cnt_Blk sequence 0,1,2,0.
REQ-039 Blk_Vld held low 10 cycles in LOAD -> no PECMAC_Sta for those cycles; Sta occurs 1 cycle after Blk_Vld rises.
REQ-040 Fnh1 pulsed during IDLE/STA and twice in WAIT -> ignored outside WAIT; WAIT exits only once Fnh0 and Fnh2 also arrive.
REQ-041 Reset asserted at position 2 -> IDLE next cycle, counters 0, no FnhRow; a fresh Row_Sta then completes normally.
REQ-042 Cfg_NumBlk=0 -> behaves as 1 (one Sta per PlsAcc); Row_Sta during a busy row -> no effect.
